// File: rtl/imm_pack_pkg.sv
// Shared definitions for the immediate-field packer: opcode classes, field
// placement constants and small helpers used by the datapath.
package imm_pack_pkg;

    typedef enum logic [1:0] {
        CLS_B   = 2'd0,
        CLS_CB  = 2'd1,
        CLS_D   = 2'd2,
        CLS_BAD = 2'd3
    } imm_cls_e;

    localparam logic [3:0] OPC_B  = 4'b0011;
    localparam logic [3:0] OPC_CB = 4'b1011;
    localparam logic [3:0] OPC_D  = 4'b1111;

    localparam int LSB_B  = 0;
    localparam int W_B    = 26;
    localparam int LSB_CB = 5;
    localparam int W_CB   = 19;
    localparam int LSB_D  = 12;
    localparam int W_D    = 9;

    // Widest field; narrower fields sit right-aligned in this width.
    localparam int FIELD_MAX_W = W_B;

    function automatic imm_cls_e decode_cls(input logic [3:0] opc);
        case (opc)
            OPC_B:   return CLS_B;
            OPC_CB:  return CLS_CB;
            OPC_D:   return CLS_D;
            default: return CLS_BAD;
        endcase
    endfunction

    function automatic logic [31:0] field_mask(input imm_cls_e cls);
        case (cls)
            CLS_B:   return ((32'd1 << W_B)  - 32'd1) << LSB_B;
            CLS_CB:  return ((32'd1 << W_CB) - 32'd1) << LSB_CB;
            CLS_D:   return ((32'd1 << W_D)  - 32'd1) << LSB_D;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] place_field(input imm_cls_e cls,
                                                input logic [FIELD_MAX_W-1:0] field);
        logic [31:0] wide;
        wide = {{(32-FIELD_MAX_W){1'b0}}, field};
        case (cls)
            CLS_B:   return (wide << LSB_B)  & field_mask(cls);
            CLS_CB:  return (wide << LSB_CB) & field_mask(cls);
            CLS_D:   return (wide << LSB_D)  & field_mask(cls);
            default: return 32'd0;
        endcase
    endfunction

endpackage

// File: rtl/imm_range_check.sv
// Combinational range check and field extraction for one immediate.
// With IMM_PACK_SAT_EN defined, out-of-range values clamp to the field limits.
module imm_range_check
    import imm_pack_pkg::*;
(
    input  logic [1:0]             cls_i,
    input  logic [63:0]            imm_i,
    output logic [FIELD_MAX_W-1:0] field_o,
    output logic                   ovf_o
);

    always_comb begin
        // NOTE: every output gets a default before the case so no path infers a latch.
        field_o = '0;
        ovf_o   = 1'b0;
        case (cls_i)
            CLS_B: begin
                field_o = imm_i[W_B-1:0];
                ovf_o   = imm_i[63:W_B-1] != {(65-W_B){imm_i[63]}};
            end
            CLS_CB: begin
                field_o = FIELD_MAX_W'(imm_i[W_CB-1:0]);
                ovf_o   = imm_i[63:W_CB-1] != {(65-W_CB){imm_i[63]}};
            end
            CLS_D: begin
                field_o = FIELD_MAX_W'(imm_i[W_D-1:0]);
                ovf_o   = imm_i[63:W_D-1] != {(65-W_D){imm_i[63]}};
            end
            default: begin
                field_o = '0;
                ovf_o   = 1'b0;
            end
        endcase

`ifdef IMM_PACK_SAT_EN
        // Clamp toward the sign of the original value.
        if (ovf_o) begin
            case (cls_i)
                CLS_B:   field_o = imm_i[63] ? 26'h200_0000 : 26'h1FF_FFFF;
                CLS_CB:  field_o = {7'b0, imm_i[63] ? 19'h4_0000 : 19'h3_FFFF};
                CLS_D:   field_o = {17'b0, imm_i[63] ? 9'h100 : 9'h0FF};
                default: field_o = '0;
            endcase
        end
`endif
    end

endmodule

// File: rtl/imm_field_packer.sv
// Two-stage immediate-field encoder with valid/ready on both sides.
// Define IMM_PACK_SAT_EN to saturate out-of-range immediates instead of truncating.
module imm_field_packer
    import imm_pack_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_tmpl,
    input  logic [63:0]      in_imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instr,
    output logic             out_ovf,
    output logic             out_badcls,
    output logic [CNT_W-1:0] ovf_count,
    input  logic             ovf_clr
);

    logic                   s1_valid_q;
    logic [31:0]            s1_tmpl_q;
    imm_cls_e               s1_cls_q;
    logic [FIELD_MAX_W-1:0] s1_field_q;
    logic                   s1_ovf_q;

    logic                   s2_valid_q;
    logic [31:0]            out_instr_q;
    logic                   out_ovf_q;
    logic                   out_badcls_q;
    logic [CNT_W-1:0]       ovf_count_q;

    imm_cls_e               in_cls;
    logic [FIELD_MAX_W-1:0] in_field;
    logic                   in_ovf;
    logic                   s1_adv;
    logic [31:0]            s2_instr_d;
    logic                   s2_badcls_d;
    logic [CNT_W-1:0]       ovf_count_d;

    assign in_cls = decode_cls(in_tmpl[31:28]);

    imm_range_check u_range_check (
        .cls_i   (in_cls),
        .imm_i   (in_imm),
        .field_o (in_field),
        .ovf_o   (in_ovf)
    );

    // Stage 1 may load whenever stage 2 is empty or draining this cycle.
    assign s1_adv   = !s2_valid_q || out_ready;
    assign in_ready = !s1_valid_q || s1_adv;

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
        end else if (in_ready) begin
            s1_valid_q <= in_valid;
        end
    end

    // NOTE: stage-1 payload has no reset; it is only consumed while s1_valid_q is set.
    always_ff @(posedge clk) begin
        if (in_ready && in_valid) begin
            s1_tmpl_q  <= in_tmpl;
            s1_cls_q   <= in_cls;
            s1_field_q <= in_field;
            s1_ovf_q   <= in_ovf;
        end
    end

    always_comb begin
        s2_badcls_d = (s1_cls_q == CLS_BAD);
        s2_instr_d  = s1_tmpl_q;
        if (!s2_badcls_d) begin
            s2_instr_d = (s1_tmpl_q & ~field_mask(s1_cls_q))
                       | place_field(s1_cls_q, s1_field_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_q   <= 1'b0;
            out_instr_q  <= '0;
            out_ovf_q    <= 1'b0;
            out_badcls_q <= 1'b0;
        end else if (s1_adv) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                out_instr_q  <= s2_instr_d;
                out_ovf_q    <= s1_ovf_q && !s2_badcls_d;
                out_badcls_q <= s2_badcls_d;
            end
        end
    end

    // Clear wins over a same-cycle increment; the count sticks at all-ones.
    always_comb begin
        ovf_count_d = ovf_count_q;
        if (ovf_clr) begin
            ovf_count_d = '0;
        end else if (s2_valid_q && out_ready && out_ovf_q && (ovf_count_q != '1)) begin
            ovf_count_d = ovf_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_count_q <= '0;
        end else begin
            ovf_count_q <= ovf_count_d;
        end
    end

    assign out_valid  = s2_valid_q;
    assign out_instr  = out_instr_q;
    assign out_ovf    = out_ovf_q;
    assign out_badcls = out_badcls_q;
    assign ovf_count  = ovf_count_q;

endmodule

// File: tb/tb_imm_field_packer.sv
// Scoreboard bench for imm_field_packer: directed vectors, backpressure,
// random traffic and mid-stream reset. Honors IMM_PACK_SAT_EN in its model.
module tb_imm_field_packer;

    localparam int CNT_W = 16;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_tmpl;
    logic [63:0]      in_imm;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_instr;
    logic             out_ovf;
    logic             out_badcls;
    logic [CNT_W-1:0] ovf_count;
    logic             ovf_clr;

    imm_field_packer #(.CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_tmpl    (in_tmpl),
        .in_imm     (in_imm),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_instr  (out_instr),
        .out_ovf    (out_ovf),
        .out_badcls (out_badcls),
        .ovf_count  (ovf_count),
        .ovf_clr    (ovf_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] instr;
        logic        ovf;
        logic        bad;
    } exp_t;

    exp_t             sb_q[$];
    int               checks   = 0;
    int               failures = 0;
    logic [CNT_W-1:0] exp_cnt  = '0;

    // Filled by tick(): what the DUT showed just before the edge, and what the model expected.
    logic             acc, dlv, sb_empty;
    exp_t             got, want;
    logic [CNT_W-1:0] obs_cnt, cnt_ref;

    // Reference model written arithmetically, independent of the RTL's bit slicing.
    function automatic exp_t model(input logic [31:0] t, input logic [63:0] imm);
        exp_t        e;
        int          w;
        int          lsb;
        longint      s;
        longint      lim;
        logic [63:0] fmask, field, placed, keep;
        e.instr = t;
        e.ovf   = 1'b0;
        e.bad   = 1'b0;
        case (t[31:28])
            4'h3:    begin w = 26; lsb = 0;  end
            4'hB:    begin w = 19; lsb = 5;  end
            4'hF:    begin w = 9;  lsb = 12; end
            default: begin w = 0;  lsb = 0;  end
        endcase
        if (w == 0) begin
            e.bad = 1'b1;
            return e;
        end
        s     = longint'(imm);
        lim   = longint'(64'd1 << (w - 1));
        e.ovf = (s < -lim) || (s >= lim);
        fmask = (64'd1 << w) - 64'd1;
        field = imm & fmask;
`ifdef IMM_PACK_SAT_EN
        if (e.ovf) field = (s < 0) ? 64'(lim) : 64'(lim - 1);
`endif
        placed  = field << lsb;
        keep    = ~(fmask << lsb);
        e.instr = (t & keep[31:0]) | placed[31:0];
        return e;
    endfunction

    // One clock: sample before the edge, update scoreboard and counter model, return #1 after the edge.
    task automatic tick();
        @(negedge clk);
        acc      = in_valid && in_ready;
        dlv      = out_valid && out_ready;
        got      = {out_instr, out_ovf, out_badcls};
        obs_cnt  = ovf_count;
        cnt_ref  = exp_cnt;
        sb_empty = 1'b0;
        want     = '0;
        if (dlv) begin
            if (sb_q.size() == 0) sb_empty = 1'b1;
            else                  want = sb_q.pop_front();
        end
        if (acc) sb_q.push_back(model(in_tmpl, in_imm));
        if (ovf_clr)                                   exp_cnt = '0;
        else if (dlv && want.ovf && (exp_cnt != '1))   exp_cnt = exp_cnt + 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_tmpl   = '0;
        in_imm    = '0;
        out_ready = 1'b1;
        ovf_clr   = 1'b0;
        #22;
        checks++;
        if ({out_valid, out_instr, out_ovf, out_badcls} !== 35'd0)
            $display("FAIL reset_outputs: got valid=%b instr=%h ovf=%b bad=%b, expected all zero",
                     out_valid, out_instr, out_ovf, out_badcls);
        if ({out_valid, out_instr, out_ovf, out_badcls} !== 35'd0) failures++;
        checks++;
        if (ovf_count !== '0) begin
            failures++;
            $display("FAIL reset_count: got %0d, expected 0", ovf_count);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_release: got in_ready=%b out_valid=%b, expected 1/0", in_ready, out_valid);
        end
    endtask

    localparam int ND = 9;
    logic [31:0] d_tmpl [ND] = '{32'h3000_0000, 32'hB400_0001, 32'hB400_0001, 32'hF800_0000,
                                 32'h1234_5678, 32'h3000_0000, 32'h3000_0000, 32'hFFFF_FFFF,
                                 32'hF000_0000};
    logic [63:0] d_imm  [ND] = '{-64'sd4, 64'sd1, -64'sd262144, 64'sd256,
                                 64'sd12345, 64'sd33554432, 64'sd33554431, -64'sd257,
                                 -64'sd256};
`ifdef IMM_PACK_SAT_EN
    logic [31:0] d_exp  [ND] = '{32'h33FF_FFFC, 32'hB400_0021, 32'hB480_0001, 32'hF80F_F000,
                                 32'h1234_5678, 32'h31FF_FFFF, 32'h31FF_FFFF, 32'hFFF0_0FFF,
                                 32'hF010_0000};
`else
    logic [31:0] d_exp  [ND] = '{32'h33FF_FFFC, 32'hB400_0021, 32'hB480_0001, 32'hF810_0000,
                                 32'h1234_5678, 32'h3200_0000, 32'h31FF_FFFF, 32'hFFEF_FFFF,
                                 32'hF010_0000};
`endif
    logic        d_ovf  [ND] = '{0, 0, 0, 1, 0, 1, 0, 1, 0};
    logic        d_bad  [ND] = '{0, 0, 0, 0, 1, 0, 0, 0, 0};
    int          d_cnt  [ND] = '{0, 0, 0, 1, 1, 2, 2, 3, 3};

    task automatic test_directed();
        int n;
        for (int i = 0; i < ND; i++) begin
            in_tmpl  = d_tmpl[i];
            in_imm   = d_imm[i];
            in_valid = 1'b1;
            n = 0;
            do begin tick(); n++; end while (!acc && n < 20);
            in_valid = 1'b0;
            n = 0;
            do begin tick(); n++; end while (!dlv && n < 20);
            checks++;
            if (!dlv || n != 2) begin
                failures++;
                $display("FAIL directed_latency[%0d]: got %0d cycles (delivered=%b), expected 2", i, n, dlv);
            end
            checks++;
            if (got !== {d_exp[i], d_ovf[i], d_bad[i]}) begin
                failures++;
                $display("FAIL directed_data[%0d]: got instr=%h ovf=%b bad=%b, expected instr=%h ovf=%b bad=%b",
                         i, got.instr, got.ovf, got.bad, d_exp[i], d_ovf[i], d_bad[i]);
            end
            tick();
            checks++;
            if (obs_cnt !== CNT_W'(d_cnt[i])) begin
                failures++;
                $display("FAIL directed_count[%0d]: got %0d, expected %0d", i, obs_cnt, d_cnt[i]);
            end
        end
    endtask

    localparam int NB = 5;
    logic [31:0] b_tmpl [NB] = '{32'hF800_0000, 32'h3ABC_0000, 32'hB000_001F, 32'hF000_0000, 32'h7000_0001};
    logic [63:0] b_imm  [NB] = '{64'sd256, 64'sd1000, -64'sd7, -64'sd300, 64'sd5};

    task automatic test_backpressure();
        int  idx      = 0;
        int  delivered = 0;
        int  n        = 0;
        bit  clr_done = 0;
        bit  clr_now;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_tmpl   = b_tmpl[0];
        in_imm    = b_imm[0];
        for (int c = 0; c < 4; c++) begin
            if (out_valid && sb_q.size() > 0) begin
                checks++;
                if ({out_instr, out_ovf, out_badcls} !== sb_q[0]) begin
                    failures++;
                    $display("FAIL stall_hold: got instr=%h, expected %h", out_instr, sb_q[0].instr);
                end
            end
            tick();
            if (acc) begin
                idx++;
                in_tmpl = b_tmpl[idx];
                in_imm  = b_imm[idx];
            end
        end
        checks++;
        if (idx != 2 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL stall_fill: got accepted=%0d in_ready=%b, expected 2/0", idx, in_ready);
        end
        out_ready = 1'b1;
        while (delivered < NB && n < 40) begin
            clr_now = out_valid && !clr_done && (sb_q.size() > 0) && sb_q[0].ovf;
            ovf_clr = clr_now;
            tick();
            ovf_clr = 1'b0;
            n++;
            if (acc) begin
                idx++;
                if (idx >= NB) in_valid = 1'b0;
                else begin
                    in_tmpl = b_tmpl[idx];
                    in_imm  = b_imm[idx];
                end
            end
            if (dlv) begin
                delivered++;
                checks++;
                if (sb_empty || got !== want) begin
                    failures++;
                    $display("FAIL bp_data: got instr=%h ovf=%b bad=%b, expected instr=%h ovf=%b bad=%b",
                             got.instr, got.ovf, got.bad, want.instr, want.ovf, want.bad);
                end
            end
            checks++;
            if (obs_cnt !== cnt_ref) begin
                failures++;
                $display("FAIL bp_count: got %0d, expected %0d", obs_cnt, cnt_ref);
            end
            if (clr_now) begin
                clr_done = 1;
                checks++;
                if (ovf_count !== '0) begin
                    failures++;
                    $display("FAIL clr_priority: got %0d, expected 0", ovf_count);
                end
            end
        end
        checks++;
        if (delivered != NB || sb_q.size() != 0 || !clr_done) begin
            failures++;
            $display("FAIL bp_total: got delivered=%0d pending=%0d clr=%0b, expected %0d/0/1",
                     delivered, sb_q.size(), clr_done, NB);
        end
    endtask

    task automatic test_random();
        logic [27:0] low;
        logic [3:0]  opc;
        longint      r;
        int          k;
        int          n = 0;
        for (int c = 0; c < 300; c++) begin
            if (!in_valid || acc) begin
                low = 28'($urandom);
                case ($urandom_range(0, 3))
                    0:       opc = 4'h3;
                    1:       opc = 4'hB;
                    2:       opc = 4'hF;
                    default: opc = 4'($urandom);
                endcase
                case ($urandom_range(0, 2))
                    0: k = 8;
                    1: k = 18;
                    default: k = 25;
                endcase
                case ($urandom_range(0, 3))
                    0:       r = {$urandom, $urandom};
                    1:       r = longint'(int'($urandom)) >>> $urandom_range(0, 24);
                    2:       r = (64'sd1 <<< k) - 2 + longint'($urandom_range(0, 2));
                    default: r = -(64'sd1 <<< k) - 1 + longint'($urandom_range(0, 2));
                endcase
                in_tmpl = {opc, low};
                in_imm  = r;
            end
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            tick();
            if (dlv) begin
                checks++;
                if (sb_empty || got !== want) begin
                    failures++;
                    $display("FAIL rand_data: got instr=%h ovf=%b bad=%b, expected instr=%h ovf=%b bad=%b",
                             got.instr, got.ovf, got.bad, want.instr, want.ovf, want.bad);
                end
            end
            checks++;
            if (obs_cnt !== cnt_ref) begin
                failures++;
                $display("FAIL rand_count: got %0d, expected %0d", obs_cnt, cnt_ref);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while (sb_q.size() > 0 && n < 20) begin
            tick();
            n++;
            if (dlv) begin
                checks++;
                if (sb_empty || got !== want) begin
                    failures++;
                    $display("FAIL rand_drain: got instr=%h, expected %h", got.instr, want.instr);
                end
            end
        end
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL rand_drain_timeout: got %0d pending, expected 0", sb_q.size());
        end
    endtask

    task automatic test_reset_mid();
        int acc_n = 0;
        int n     = 0;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_tmpl   = 32'hB000_0000;
        in_imm    = 64'sd3;
        while (acc_n < 2 && n < 10) begin
            tick();
            n++;
            if (acc) begin
                acc_n++;
                in_imm = 64'sd4;
            end
        end
        rst_n = 1'b0;
        #2;
        checks++;
        if (acc_n != 2 || out_valid !== 1'b0 || out_instr !== 32'd0 || ovf_count !== '0) begin
            failures++;
            $display("FAIL mid_reset: got accepted=%0d out_valid=%b instr=%h count=%0d, expected 2/0/0/0",
                     acc_n, out_valid, out_instr, ovf_count);
        end
        in_valid = 1'b0;
        sb_q.delete();
        exp_cnt = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL mid_release: got in_ready=%b out_valid=%b, expected 1/0", in_ready, out_valid);
        end
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_tmpl   = 32'h3000_0000;
        in_imm    = 64'sd100;
        n = 0;
        do begin tick(); n++; end while (!acc && n < 10);
        in_valid = 1'b0;
        n = 0;
        do begin tick(); n++; end while (!dlv && n < 10);
        checks++;
        if (!dlv || n != 2 || sb_empty || got !== want || got.instr !== 32'h3000_0064) begin
            failures++;
            $display("FAIL mid_next: got %0d cycles instr=%h, expected 2 cycles instr=30000064", n, got.instr);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
